// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the single integer register-file write port plus a
// per-register pending-write scoreboard used by issue for RAW/WAW stalls.
// Build option: define WBARB_RR_EN for round-robin arbitration between EXU
// and LSU; without it the LSU has fixed priority on contention.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    input  logic [4:0]        exu_addr,
    input  logic [DATA_W-1:0] exu_data,
    output logic              exu_ready,
    input  logic              lsu_valid,
    input  logic [4:0]        lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              w_ena,
    output logic [4:0]        w_addr,
    output logic [DATA_W-1:0] w_data,
    input  logic              sb_set,
    input  logic [4:0]        sb_addr,
    output logic              sb_set_ok,
    input  logic [4:0]        rs1_addr,
    output logic              rs1_busy,
    input  logic [4:0]        rs2_addr,
    output logic              rs2_busy,
    output logic              sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [32];
    logic             gnt_exu;
    logic             gnt_lsu;
    logic             both_vld;
    logic             inc_ok;

    // Next pending count: a same-register set and commit cancel out, and a
    // commit never takes the count below zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic             inc,
                                                  input logic             dec);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec)
            nxt = cur + 1'b1;
        else if (dec && !inc && cur != '0)
            nxt = cur - 1'b1;
        return nxt;
    endfunction

    assign both_vld = exu_valid && lsu_valid;

`ifdef WBARB_RR_EN
    logic rr_ptr;

    // Grant a lone requester; on contention rr_ptr picks (0 = EXU, 1 = LSU)
    always_comb begin
        gnt_exu = 1'b0;
        gnt_lsu = 1'b0;
        if (rst) begin
            if (both_vld) begin
                gnt_exu = !rr_ptr;
                gnt_lsu = rr_ptr;
            end else begin
                gnt_exu = exu_valid;
                gnt_lsu = lsu_valid;
            end
        end
    end

    // After a contended grant the pointer moves to the source that lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= 1'b0;
        else if (both_vld)
            rr_ptr <= gnt_exu;
    end
`else
    // Grant a lone requester; on contention the LSU always wins
    always_comb begin
        gnt_exu = 1'b0;
        gnt_lsu = 1'b0;
        if (rst) begin
            gnt_lsu = lsu_valid;
            gnt_exu = exu_valid && !lsu_valid;
        end
    end
`endif

    assign exu_ready = gnt_exu;
    assign lsu_ready = gnt_lsu;

    // Query ports see the counters before this cycle's updates (no bypass)
    assign sb_set_ok = (cnt[sb_addr] != CNT_MAX);
    assign rs1_busy  = (cnt[rs1_addr] != '0);
    assign rs2_busy  = (cnt[rs2_addr] != '0);
    assign inc_ok    = sb_set && sb_set_ok && (sb_addr != 5'd0);

    // Register the granted write-back; x0 is consumed without a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ena  <= 1'b0;
            w_addr <= 5'd0;
            w_data <= '0;
        end else begin
            w_ena <= 1'b0;
            if (gnt_exu) begin
                if (exu_addr != 5'd0) begin
                    w_ena  <= 1'b1;
                    w_addr <= exu_addr;
                    w_data <= exu_data;
                end
            end else if (gnt_lsu) begin
                if (lsu_addr != 5'd0) begin
                    w_ena  <= 1'b1;
                    w_addr <= lsu_addr;
                    w_data <= lsu_data;
                end
            end
        end
    end

    // Scoreboard: dispatch increments, register-file write commits; x0 stays 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++)
                cnt[i] <= cnt_next(cnt[i],
                                   inc_ok && (sb_addr == 5'(i)),
                                   w_ena && (w_addr == 5'(i)));
            if (w_ena && cnt[w_addr] == '0)
                sb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios and randomized traffic
// driven through one stimulus task that also steps a reference model; the
// expected register-file write for each cycle is queued and a separate
// monitor compares it against the write port.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 64;
    localparam int MAXC   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              exu_valid = 1'b0;
    logic [4:0]        exu_addr = '0;
    logic [DATA_W-1:0] exu_data = '0;
    logic              exu_ready;
    logic              lsu_valid = 1'b0;
    logic [4:0]        lsu_addr = '0;
    logic [DATA_W-1:0] lsu_data = '0;
    logic              lsu_ready;
    logic              w_ena;
    logic [4:0]        w_addr;
    logic [DATA_W-1:0] w_data;
    logic              sb_set = 1'b0;
    logic [4:0]        sb_addr = '0;
    logic              sb_set_ok;
    logic [4:0]        rs1_addr = '0;
    logic              rs1_busy;
    logic [4:0]        rs2_addr = '0;
    logic              rs2_busy;
    logic              sb_err;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_addr(exu_addr), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_set_ok(sb_set_ok),
        .rs1_addr(rs1_addr), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_busy(rs2_busy),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              ena;
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t expq[$];
    int  nvec = 0;
    int  nmis = 0;

    // reference model state
    int  m_cnt[32];
    bit  m_err;
    bit  m_turn_lsu;
    wr_t m_wr;
    bit  last_g_exu, last_g_lsu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err      = 0;
        m_turn_lsu = 0;
        m_wr       = '0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, then at the edge advance the model and queue the expected write.
    task automatic step(input logic ev, input logic [4:0] ea, input logic [63:0] ed,
                        input logic lv, input logic [4:0] la, input logic [63:0] ld,
                        input logic ss, input logic [4:0] sa,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit  g_exu, g_lsu, both, inc, com;
        int  wa;
        wr_t nxt;
        #1;
        exu_valid = ev; exu_addr = ea; exu_data = ed;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        sb_set = ss; sb_addr = sa; rs1_addr = r1; rs2_addr = r2;
        both  = ev && lv;
        g_exu = 0;
        g_lsu = 0;
        if (both) begin
`ifdef WBARB_RR_EN
            if (m_turn_lsu) g_lsu = 1; else g_exu = 1;
`else
            g_lsu = 1;
`endif
        end else begin
            g_exu = ev;
            g_lsu = lv;
        end
        #1;
        chk("exu_ready", exu_ready, g_exu);
        chk("lsu_ready", lsu_ready, g_lsu);
        chk("sb_set_ok", sb_set_ok, m_cnt[sa] < MAXC);
        chk("rs1_busy",  rs1_busy,  m_cnt[r1] != 0);
        chk("rs2_busy",  rs2_busy,  m_cnt[r2] != 0);
        chk("sb_err",    sb_err,    m_err);
        last_g_exu = g_exu;
        last_g_lsu = g_lsu;
        inc = ss && (m_cnt[sa] < MAXC) && (sa != 0);
        com = m_wr.ena;
        wa  = int'(m_wr.addr);
        nxt = m_wr;
        nxt.ena = 1'b0;
        if (g_exu && ea != 0) nxt = {1'b1, ea, ed};
        else if (g_lsu && la != 0) nxt = {1'b1, la, ld};
        @(posedge clk);
        if (com && m_cnt[wa] == 0) m_err = 1;
        if (!(inc && com && int'(sa) == wa)) begin
            if (com && m_cnt[wa] > 0) m_cnt[wa]--;
            if (inc) m_cnt[sa]++;
        end
        if (both) m_turn_lsu = g_exu;
        m_wr = nxt;
        expq.push_back(nxt);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Assert reset between edges, check the async-cleared state, release
    task automatic apply_reset(input int cycles);
        #1;
        rst = 1'b0;
        exu_valid = 0; lsu_valid = 0; sb_set = 0;
        expq.delete();
        model_clear();
        #1;
        chk("rst_w_ena",     w_ena,     1'b0);
        chk("rst_w_addr",    w_addr,    5'd0);
        chk("rst_w_data",    w_data,    64'd0);
        chk("rst_exu_ready", exu_ready, 1'b0);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        chk("rst_sb_set_ok", sb_set_ok, 1'b1);
        chk("rst_rs1_busy",  rs1_busy,  1'b0);
        chk("rst_rs2_busy",  rs2_busy,  1'b0);
        chk("rst_sb_err",    sb_err,    1'b0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: the write port presents one result per cycle
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("w_ena",  w_ena,  e.ena);
                chk("w_addr", w_addr, e.addr);
                chk("w_data", w_data, e.data);
            end
        end
    end

    initial begin
        logic            ev, lv, ss;
        logic [4:0]      ea, la, sa, r1, r2;
        logic [63:0]     ed, ld;
        bit              pend_e, pend_l;

        model_clear();
        apply_reset(2);

        // single source write-back
        step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 5, 0);
        idle(5, 0);
        idle(5, 0);

        // contention for four cycles
        for (int i = 0; i < 4; i++)
            step(1, 3, 64'hE0 + i, 1, 4, 64'hA0 + i, 0, 0, 3, 4);
        idle(3, 4);
        idle(3, 4);
        apply_reset(1);

        // scoreboard count to saturation, refused fourth set, then drain
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        for (int i = 0; i < 3; i++) step(1, 7, 64'h700 + i, 0, 0, 0, 0, 0, 7, 0);
        idle(7, 0);
        idle(7, 0);

        // same-cycle set and commit on reg 9
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        step(1, 9, 64'h99, 0, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        idle(0, 9);
        idle(0, 9);

        // x0 write-back, then commit on a zero counter
        step(0, 0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0);
        idle(0, 0);
        step(1, 12, 64'hC0C0, 0, 0, 0, 0, 0, 12, 0);
        idle(12, 0);
        idle(12, 0);
        idle(12, 0);

        // reset while a write is in flight
        apply_reset(1);
        step(0, 0, 0, 0, 0, 0, 1, 20, 20, 21);
        step(0, 0, 0, 0, 0, 0, 1, 21, 20, 21);
        step(1, 20, 64'h2020, 0, 0, 0, 0, 0, 20, 21);
        #1;
        chk("pre_rst_w_ena", w_ena, m_wr.ena);
        apply_reset(2);
        idle(20, 21);
        idle(20, 21);

        // randomized traffic; requesters hold their request until granted
        pend_e = 0;
        pend_l = 0;
        ea = 0; ed = 0; la = 0; ld = 0; ev = 0; lv = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend_e) begin
                ev = ($urandom_range(0, 2) != 0);
                ea = 5'($urandom_range(0, 7));
                ed = {$urandom, $urandom};
            end
            if (!pend_l) begin
                lv = ($urandom_range(0, 2) != 0);
                la = 5'($urandom_range(0, 7));
                ld = {$urandom, $urandom};
            end
            ss = ($urandom_range(0, 1) != 0);
            sa = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            step(ev, ea, ed, lv, la, ld, ss, sa, r1, r2);
            pend_e = ev && !last_g_exu;
            pend_l = lv && !last_g_lsu;
            if (n == 1500) begin
                apply_reset(1);
                pend_e = 0;
                pend_l = 0;
            end
        end
        idle(0, 0);
        idle(0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and register scoreboard in front of the integer register file. Two write-back sources (execute unit and load/store unit) share the register file's single write port. The block grants one source per cycle and drives the registered write port (`w_addr`/`w_data`/`w_ena`). It also keeps a per-register pending-write counter so issue logic can stall on RAW/WAW hazards.

## Interface

Parameters:
- `DATA_W`, 64: write-back data width; matches `REG_BUS`.
- `CNT_W`, 2: pending-write counter width per register; max pending = 2^CNT_W-1.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `exu_valid` in 1: execute unit has a write-back.
- `exu_addr` in 5: destination register.
- `exu_data` in DATA_W: write-back data.
- `exu_ready` out 1: EXU write-back accepted this cycle.
- `lsu_valid` in 1: LSU has a write-back.
- `lsu_addr` in 5: destination register.
- `lsu_data` in DATA_W: write-back data.
- `lsu_ready` out 1: LSU write-back accepted this cycle.
- `w_ena` out 1: register file write enable (registered).
- `w_addr` out 5: register file write address (registered).
- `w_data` out DATA_W: register file write data (registered).
- `sb_set` in 1: issue stage dispatches an instruction writing `sb_addr`.
- `sb_addr` in 5: destination of the dispatched instruction.
- `sb_set_ok` out 1: combinational; counter[`sb_addr`] not saturated.
- `rs1_addr` in 5: first query address.
- `rs1_busy` out 1: combinational; counter[`rs1_addr`] != 0.
- `rs2_addr` in 5: second query address.
- `rs2_busy` out 1: combinational; counter[`rs2_addr`] != 0.
- `sb_err` out 1: sticky; a commit hit a zero counter.

## Operation

- **Handshake:**
  - A transfer occurs when `X_valid && X_ready`.
  - `X_ready` is a combinational grant; it never depends on downstream back-pressure, because the write port accepts one write every cycle.
  - Requesters hold addr/data stable while valid and not ready.
- **Arbitration:**
  - Only one source valid: that source is granted.
  - Both valid: `rr_ptr` selects (0 = EXU, 1 = LSU).
  - After a both-valid grant, `rr_ptr` points to the loser.
  - Single-valid grants leave `rr_ptr` unchanged.
- **Output register:** on a grant with addr != 0, the next cycle has `w_ena`=1 and `w_addr`/`w_data` equal to the granted values. Otherwise `w_ena`=0 and `w_addr`/`w_data` hold their last values.
- **x0 write-back:** is granted and consumed, but produces no `w_ena` and no commit.
- **Scoreboard:** 32 counters of CNT_W bits; counter 0 is hardwired to 0.
  - Increment when `sb_set && sb_set_ok && sb_addr != 0`.
  - Decrement (commit) when `w_ena`=1, on `w_addr`.
  - `sb_set` with `sb_set_ok`=0 is ignored; the issue stage must stall.
- **Simultaneous increment and commit:**
  - Same register: counter unchanged.
  - Different registers: both updates apply.
- **Error:** commit on a zero counter leaves the counter at 0 and sets `sb_err`, which stays set until reset.
- **Query ports:** read counter state *before* this cycle's updates; there is no bypass.

## Timing

- Grant to register-file write latency: 1 cycle; the commit occurs in the same cycle as `w_ena`.
- Counter cleared by a commit in cycle N: `rsX_busy` drops in cycle N+1.
- Reset values: `w_ena`=0, `w_addr`=0, `w_data`=0, `rr_ptr`=0, all counters 0, `sb_err`=0.
- While `rst` is low: `exu_ready`=`lsu_ready`=0, `sb_set_ok`=1, and `rs1_busy`/`rs2_busy` follow the counter values, which are 0.
- Reset asserted mid-operation:
  - An in-flight `w_ena` is cleared asynchronously; that write is lost.
  - All pending counts are discarded.
- Throughput: one write-back per cycle. A source that is continuously valid against a contender is granted at least every second cycle (round-robin).

## Configuration

- `WBARB_RR_EN` defined: round-robin arbitration as described above.
- `WBARB_RR_EN` undefined:
  - Fixed priority: LSU always wins when both sources are valid.
  - `rr_ptr` is not implemented.
  - All other behaviour is identical.

## Test plan

- **Single source:** reset, then `exu_valid`=1, `exu_addr`=5, `exu_data`=0x1234 → `exu_ready`=1 that cycle; next cycle `w_ena`=1, `w_addr`=5, `w_data`=0x1234.
- **Contention:** both valid for 4 cycles, addrs 3/4 (`WBARB_RR_EN` defined) → grants EXU, LSU, EXU, LSU. Undefined → LSU ×4, with `exu_ready`=0 throughout.
- **Scoreboard count and clear:** `sb_set` on reg 7 three times → `sb_set_ok`=0 on a fourth attempt and `rs1_busy`=1 for `rs1_addr`=7. Three write-backs to reg 7 → `rs1_busy`=0 the cycle after the third `w_ena`.
- **Same-cycle set and commit:** counter[9]=1, then `sb_set` on reg 9 in the same cycle as its commit → counter stays 1 and `rs2_busy` stays 1.
- **x0 and error:** LSU write-back to reg 0 → `lsu_ready`=1, `w_ena`=0 next cycle, no counter change. EXU write-back to reg 12 with counter 0 → `w_ena`=1 and `sb_err`=1 from the following cycle, held until `rst` goes low.
- **Reset mid-write:** grant in cycle N, `rst` low in cycle N+1 → `w_ena`=0 immediately; after reset release all busy outputs are 0.
